if_fetch_unit: RTL

Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register. It owns the PC and issues requests to a variable-latency instruction memory. It presents InstrF and PCPlus4F, and drives IF_Stall and IF_Flush so that the IF/ID register either holds, loads the fetched instruction, or loads a bubble (32'b0). It accepts the stall and branch-redirect signals produced in ID.

---
 rtl/if_fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding request at a time, and feeds IF/ID.
// InstrF is combinational from imem_rdata; a word that lands under StallD is parked in buf.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        BranchD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        IF_Stall,
  output logic        IF_Flush
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    VALID   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        valid_f;

  // A branch under StallD is dropped; the hazard unit re-asserts it once ID moves.
  assign redirect = BranchD & ~StallD;
  assign pc_plus4 = pc_q + 32'd4;
  assign valid_f  = (state_q == VALID) | ((state_q == FETCH) & imem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      buf_q      <= 32'h0;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d = PCBranchD;
          end else begin
            // Request stays outstanding; remember where to go once it drains.
            redir_pc_d = PCBranchD;
            state_d    = DISCARD;
          end
        end else if (imem_ready) begin
          if (StallD) begin
            buf_d   = imem_rdata;
            state_d = VALID;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      VALID: begin
        if (redirect) begin
          pc_d    = PCBranchD;
          state_d = FETCH;
        end else if (!StallD) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          redir_pc_d = PCBranchD;
        end
        if (imem_ready) begin
          pc_d    = redirect ? PCBranchD : redir_pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    imem_req  = (state_q != VALID);
    imem_addr = pc_q;
    InstrF    = (state_q == VALID) ? buf_q : imem_rdata;
    PCPlus4F  = pc_plus4;
    IF_Stall  = StallD;
    IF_Flush  = ~StallD & (redirect | ~valid_f);
  end

endmodule
